// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HOLD
  } state_t;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_hold_buf.sv
// Skid register that keeps a returned instruction word while the decoder is not accepting.
module fetch_hold_buf
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INST = fetch_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        capture,
  input  logic        clear,
  input  logic [31:0] data,
  output logic [31:0] hold_inst,
  output logic        hold_valid
);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_inst  <= NOP_INST;
      hold_valid <= 1'b0;
    end else if (clear) begin
      hold_valid <= 1'b0;
    end else if (capture) begin
      hold_inst  <= data;
      hold_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues PCs to a synchronous-read imem, handles decoder
// back-pressure with a skid register, and squashes wrong-path words on redirects.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = fetch_pkg::DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INST = fetch_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        trap_taken,
  input  logic [31:0] trap_target,
  input  logic        stall_flag,
  input  logic        ds_allowin,
  output logic        fs_to_ds_valid,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out
);

  state_t      state, next_state;
  logic [31:0] pc_f, pc_d;
  logic        d_valid;
  logic [31:0] hold_inst;
  logic        hold_valid;

  logic        adv, redirect;
  logic [31:0] target;

  assign adv      = ds_allowin & ~stall_flag;
  assign redirect = trap_taken | br_taken;
  assign target   = trap_taken ? trap_target : br_target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= next_state;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    if (redirect) begin
      next_state = RUN;
    end else begin
      case (state)
        BOOT:    next_state = RUN;
        RUN:     if (!adv) next_state = HOLD;
        HOLD:    if (adv)  next_state = RUN;
        default: next_state = BOOT;
      endcase
    end
  end

  // BOOT behaves like an advance: the RESET_PC word is already in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f    <= RESET_PC;
      pc_d    <= 32'h0;
      d_valid <= 1'b0;
    end else if (redirect) begin
      pc_d    <= target;
      pc_f    <= target + 32'd4;
      d_valid <= 1'b1;
    end else if (state == BOOT || adv) begin
      pc_d    <= pc_f;
      pc_f    <= pc_f + 32'd4;
      d_valid <= 1'b1;
    end
  end

  fetch_hold_buf #(
    .NOP_INST (NOP_INST)
  ) u_hold_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .capture    (state == RUN && !adv && !redirect),
    .clear      (redirect || (state == HOLD && adv)),
    .data       (imem_rdata),
    .hold_inst  (hold_inst),
    .hold_valid (hold_valid)
  );

  // Requests track reset directly so the BOOT cycle already reads RESET_PC.
  always_comb begin
    imem_req       = rst_n;
    imem_addr      = redirect ? target : pc_f;
    pc_out         = pc_d;
    fs_to_ds_valid = d_valid & ~redirect;
    inst_out       = NOP_INST;
    if (!redirect) begin
      if (hold_valid)   inst_out = hold_inst;
      else if (d_valid) inst_out = imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage against a synchronous imem holding word index at each word.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata = 32'h0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        trap_taken = 1'b0;
  logic [31:0] trap_target = 32'h0;
  logic        stall_flag = 1'b0;
  logic        ds_allowin = 1'b1;
  logic        fs_to_ds_valid;
  logic [31:0] pc_out;
  logic [31:0] inst_out;

  int n_assert = 0;
  int n_fail   = 0;

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_req       (imem_req),
    .imem_rdata     (imem_rdata),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .trap_taken     (trap_taken),
    .trap_target    (trap_target),
    .stall_flag     (stall_flag),
    .ds_allowin     (ds_allowin),
    .fs_to_ds_valid (fs_to_ds_valid),
    .pc_out         (pc_out),
    .inst_out       (inst_out)
  );

  always #5 clk = ~clk;

  // Memory model: the word at byte address a holds a>>2, returned one cycle later.
  always @(posedge clk) imem_rdata <= imem_addr >> 2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] pc,
                            input logic [31:0] inst);
    check({tag, " valid"}, {31'h0, fs_to_ds_valid}, {31'h0, v});
    check({tag, " pc"}, pc_out, pc);
    check({tag, " inst"}, inst_out, inst);
  endtask

  task automatic expect_reset(input string tag);
    expect_out(tag, 1'b0, 32'h0, NOP);
    check({tag, " req"}, {31'h0, imem_req}, 32'h0);
    check({tag, " addr"}, imem_addr, 32'h0);
  endtask

  initial begin
    #3;
    expect_reset("reset");

    // Release reset: one BOOT cycle, then pc 0,4,8 with inst 0,1,2.
    next_cycle();
    rst_n = 1'b1;
    mid();
    check("boot valid", {31'h0, fs_to_ds_valid}, 32'h0);
    check("boot req", {31'h0, imem_req}, 32'h1);
    check("boot addr", imem_addr, 32'h0);
    next_cycle(); mid();
    expect_out("run0", 1'b1, 32'h0, 32'h0);
    check("run0 addr", imem_addr, 32'h4);
    next_cycle(); mid();
    expect_out("run1", 1'b1, 32'h4, 32'h1);

    // Three stalled cycles at pc 8, then the consuming cycle, then pc 12.
    next_cycle(); stall_flag = 1'b1; mid();
    expect_out("stall0", 1'b1, 32'h8, 32'h2);
    next_cycle(); mid();
    expect_out("stall1", 1'b1, 32'h8, 32'h2);
    check("stall1 addr", imem_addr, 32'hC);
    next_cycle(); mid();
    expect_out("stall2", 1'b1, 32'h8, 32'h2);
    next_cycle(); stall_flag = 1'b0; mid();
    expect_out("unstall", 1'b1, 32'h8, 32'h2);
    next_cycle(); mid();
    expect_out("after stall", 1'b1, 32'hC, 32'h3);
    next_cycle(); mid();
    expect_out("pc10", 1'b1, 32'h10, 32'h4);

    // Branch at pc 0x10 (data issued this cycle).
    br_taken = 1'b1; br_target = 32'h100; #1;
    check("br addr", imem_addr, 32'h100);
    check("br valid", {31'h0, fs_to_ds_valid}, 32'h0);
    check("br inst", inst_out, NOP);
    next_cycle(); br_taken = 1'b0; mid();
    expect_out("br target", 1'b1, 32'h100, 32'h40);
    next_cycle(); mid();
    expect_out("br seq", 1'b1, 32'h104, 32'h41);

    // Trap beats branch in the same cycle.
    next_cycle();
    trap_taken = 1'b1; trap_target = 32'h200; br_taken = 1'b1; br_target = 32'h100;
    mid();
    check("trap addr", imem_addr, 32'h200);
    check("trap valid", {31'h0, fs_to_ds_valid}, 32'h0);
    next_cycle(); trap_taken = 1'b0; br_taken = 1'b0; mid();
    expect_out("trap target", 1'b1, 32'h200, 32'h80);

    // Redirect while holding (also stalled): hold content must be discarded.
    next_cycle(); ds_allowin = 1'b0; mid();
    expect_out("pre hold", 1'b1, 32'h204, 32'h81);
    next_cycle(); br_taken = 1'b1; br_target = 32'h300; stall_flag = 1'b1; mid();
    check("hold br addr", imem_addr, 32'h300);
    check("hold br valid", {31'h0, fs_to_ds_valid}, 32'h0);
    check("hold br inst", inst_out, NOP);
    next_cycle(); br_taken = 1'b0; stall_flag = 1'b0; ds_allowin = 1'b1; mid();
    expect_out("hold br target", 1'b1, 32'h300, 32'hC0);

    // Reset pulsed mid-HOLD.
    next_cycle(); stall_flag = 1'b1; mid();
    expect_out("hold2 entry", 1'b1, 32'h304, 32'hC1);
    next_cycle(); mid();
    expect_out("hold2", 1'b1, 32'h304, 32'hC1);
    #1; rst_n = 1'b0; #1;
    expect_reset("mid-hold reset");
    next_cycle(); stall_flag = 1'b0; rst_n = 1'b1; mid();
    check("reboot valid", {31'h0, fs_to_ds_valid}, 32'h0);
    check("reboot addr", imem_addr, 32'h0);
    next_cycle(); mid();
    expect_out("restart", 1'b1, 32'h0, 32'h0);

    // PC wraps modulo 2^32.
    next_cycle(); br_taken = 1'b1; br_target = 32'hFFFF_FFFC; mid();
    check("wrap br addr", imem_addr, 32'hFFFF_FFFC);
    next_cycle(); br_taken = 1'b0; mid();
    expect_out("wrap top", 1'b1, 32'hFFFF_FFFC, 32'h3FFF_FFFF);
    check("wrap addr", imem_addr, 32'h0);
    next_cycle(); mid();
    expect_out("wrap zero", 1'b1, 32'h0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
